// File: rtl/register_file.sv
// register_file: 32x32 integer register file, two async read ports, one write port, x0 hardwired to zero.
// Define REGISTER_FILE_BYPASS_EN to forward same-cycle write data to the read ports.
module register_file #(
    parameter int N     = 32,
    parameter int NREGS = 32,
    parameter int A     = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_ena,
    input  logic [A-1:0] wr_addr,
    input  logic [N-1:0] wr_data,
    input  logic [A-1:0] rd_addr0,
    output logic [N-1:0] rd_data0,
    input  logic [A-1:0] rd_addr1,
    output logic [N-1:0] rd_data1
);
    logic [N-1:0] r_regs [1:NREGS-1];
    logic         w_fwd0;
    logic         w_fwd1;

    for (genvar i = 1; i < NREGS; i++) begin : g_reg
        always_ff @(posedge clk or negedge rst) begin
            if (!rst)
                r_regs[i] <= '0;
            else if (wr_ena && wr_addr == A'(i))
                r_regs[i] <= wr_data;
        end
    end

`ifdef REGISTER_FILE_BYPASS_EN
    assign w_fwd0 = wr_ena && rst && wr_addr != '0 && rd_addr0 == wr_addr;
    assign w_fwd1 = wr_ena && rst && wr_addr != '0 && rd_addr1 == wr_addr;
`else
    assign w_fwd0 = 1'b0;
    assign w_fwd1 = 1'b0;
`endif

    // x0 has no storage, so the zero check also keeps the array index in range
    assign rd_data0 = rd_addr0 == '0 ? '0 : w_fwd0 ? wr_data : r_regs[rd_addr0];
    assign rd_data1 = rd_addr1 == '0 ? '0 : w_fwd1 ? wr_data : r_regs[rd_addr1];
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: randomized self-checking bench for register_file against an array model.
module tb_register_file;
    logic        clk = 1'b0;
    logic        rst;
    logic        wr_ena;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  rd_addr0;
    logic [31:0] rd_data0;
    logic [4:0]  rd_addr1;
    logic [31:0] rd_data1;
    logic [31:0] m [32];
    int          total = 0;
    int          bad = 0;

    register_file dut (
        .clk(clk), .rst(rst), .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr0(rd_addr0), .rd_data0(rd_data0), .rd_addr1(rd_addr1), .rd_data1(rd_data1)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_rd(input logic [4:0] ra);
`ifdef REGISTER_FILE_BYPASS_EN
        if (wr_ena && rst && wr_addr != 0 && ra == wr_addr && ra != 0) return wr_data;
`endif
        return (ra == 0 || !rst) ? 32'h0 : m[ra];
    endfunction

    task automatic write_reg(input logic en, input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        wr_ena = en; wr_addr = a; wr_data = d;
        @(posedge clk);
        if (en && a != 0 && rst) m[a] = d;
        #1 wr_ena = 1'b0;
    endtask

    task automatic test_reset;
        for (int k = 0; k < 6; k++) begin
            rd_addr0 = 5'($urandom); rd_addr1 = 5'($urandom);
            #1;
            total++;
            if (rd_data0 !== 32'h0 || rd_data1 !== 32'h0) begin
                bad++;
                $display("FAIL reset_read a0=%0d a1=%0d got %h/%h want 0", rd_addr0, rd_addr1, rd_data0, rd_data1);
            end
        end
        @(negedge clk) rst = 1'b1;
        write_reg(1'b1, 5'd5, 32'hDEAD_BEEF);
        rd_addr0 = 5; #1;
        total++;
        if (rd_data0 !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL first_write got %h want deadbeef", rd_data0);
        end
    endtask

    task automatic test_x0;
        write_reg(1'b1, 5'd0, 32'hFFFF_FFFF);
        rd_addr0 = 0; rd_addr1 = 0; #1;
        total++;
        if (rd_data0 !== 32'h0 || rd_data1 !== 32'h0) begin
            bad++; $display("FAIL x0_write got %h/%h want 0", rd_data0, rd_data1);
        end
    endtask

    task automatic test_sweep;
        for (int i = 1; i < 32; i++) write_reg(1'b1, 5'(i), 32'(i) * 32'h0101_0101);
        for (int i = 0; i < 32; i++) begin
            rd_addr0 = 5'(i); rd_addr1 = 5'(31 - i); #1;
            total++;
            if (rd_data0 !== 32'(i) * 32'h0101_0101 || rd_data1 !== 32'(31 - i) * 32'h0101_0101) begin
                bad++;
                $display("FAIL sweep i=%0d got %h/%h want %h/%h", i, rd_data0, rd_data1,
                         32'(i) * 32'h0101_0101, 32'(31 - i) * 32'h0101_0101);
            end
        end
    endtask

    task automatic test_rdw;
        logic [31:0] pre;
        write_reg(1'b1, 5'd7, 32'h1234);
        @(negedge clk);
        wr_ena = 1'b1; wr_addr = 7; wr_data = 32'hABCD; rd_addr0 = 7; rd_addr1 = 7;
`ifdef REGISTER_FILE_BYPASS_EN
        pre = 32'hABCD;
`else
        pre = 32'h1234;
`endif
        #1;
        total++;
        if (rd_data0 !== pre || rd_data1 !== pre) begin
            bad++; $display("FAIL rdw_before got %h/%h want %h", rd_data0, rd_data1, pre);
        end
        @(posedge clk);
        m[7] = 32'hABCD;
        #1 wr_ena = 1'b0; #1;
        total++;
        if (rd_data0 !== 32'hABCD || rd_data1 !== 32'hABCD) begin
            bad++; $display("FAIL rdw_after got %h/%h want abcd", rd_data0, rd_data1);
        end
    endtask

    task automatic test_async_reset;
        write_reg(1'b1, 5'd3, 32'h55);
        rd_addr0 = 3; rd_addr1 = 5;
        #2 rst = 1'b0;
        for (int i = 0; i < 32; i++) m[i] = 32'h0;
        #1;
        total++;
        if (rd_data0 !== 32'h0 || rd_data1 !== 32'h0) begin
            bad++; $display("FAIL async_clear got %h/%h want 0", rd_data0, rd_data1);
        end
        wr_ena = 1'b1; wr_addr = 3; wr_data = 32'h77;
        @(posedge clk);
        @(negedge clk);
        wr_ena = 1'b0; rst = 1'b1; #1;
        total++;
        if (rd_data0 !== 32'h0) begin
            bad++; $display("FAIL write_in_reset got %h want 0", rd_data0);
        end
    endtask

    task automatic test_wr_dis;
        write_reg(1'b1, 5'd9, 32'hCAFE_F00D);
        for (int k = 0; k < 10; k++) write_reg(1'b0, 5'($urandom), $urandom);
        for (int i = 0; i < 32; i++) begin
            rd_addr0 = 5'(i); rd_addr1 = 5'(31 - i); #1;
            total++;
            if (rd_data0 !== exp_rd(5'(i)) || rd_data1 !== exp_rd(5'(31 - i))) begin
                bad++;
                $display("FAIL wr_dis i=%0d got %h/%h want %h/%h", i, rd_data0, rd_data1,
                         exp_rd(5'(i)), exp_rd(5'(31 - i)));
            end
        end
    endtask

    task automatic test_random;
        logic [31:0] e0, e1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            wr_ena = 1'($urandom); wr_addr = 5'($urandom); wr_data = $urandom;
            rd_addr0 = ($urandom_range(3) == 0) ? wr_addr : 5'($urandom);
            rd_addr1 = 5'($urandom);
            #1;
            e0 = exp_rd(rd_addr0); e1 = exp_rd(rd_addr1);
            total++;
            if (rd_data0 !== e0 || rd_data1 !== e1) begin
                bad++;
                $display("FAIL random k=%0d a=%0d/%0d got %h/%h want %h/%h", k, rd_addr0, rd_addr1,
                         rd_data0, rd_data1, e0, e1);
            end
            @(posedge clk);
            if (wr_ena && wr_addr != 0) m[wr_addr] = wr_data;
        end
        @(negedge clk) wr_ena = 1'b0;
    endtask

    initial begin
        rst = 1'b0; wr_ena = 1'b0; wr_addr = 0; wr_data = 0; rd_addr0 = 0; rd_addr1 = 0;
        for (int i = 0; i < 32; i++) m[i] = 32'h0;
        #3;
        test_reset;
        test_x0;
        test_sweep;
        test_rdw;
        test_async_reset;
        test_wr_dis;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
